// File: rtl/mont_exit_reducer_if.sv
// Handshake bundle for mont_exit_reducer.
//   in_valid/in_ready/X    : operand channel (master -> slave)
//   out_valid/out_ready/O  : result channel  (slave -> master)
//   busy                   : slave is not idle
// slave modport is the reducer side; master modport is the producer/consumer.
interface mont_exit_reducer_if #(
  parameter int unsigned BIT_LEN = 256
);
  logic               in_valid;
  logic               in_ready;
  logic [BIT_LEN-1:0] X;
  logic               out_valid;
  logic               out_ready;
  logic [BIT_LEN-1:0] O;
  logic               busy;

  modport slave (
    input  in_valid, X, out_ready,
    output in_ready, out_valid, O, busy
  );

  modport master (
    output in_valid, X, out_ready,
    input  in_ready, out_valid, O, busy
  );
endinterface

// File: rtl/mont_exit_reducer.sv
// mont_exit_reducer: converts a value out of the Montgomery domain,
// O = X * 2^-BIT_LEN mod P, using an iterative multiplier-free REDC that
// retires BITS_PER_CYCLE bit-steps per clock.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - slave side of mont_exit_reducer_if: X accepted on
//            in_valid&in_ready, O delivered on out_valid&out_ready, busy
//            high whenever not idle.
// BITS_PER_CYCLE must be 1, 2 or 4 and divide BIT_LEN; P must be odd.
module mont_exit_reducer #(
  parameter int unsigned        BIT_LEN        = 256,
  parameter int unsigned        BITS_PER_CYCLE = 1,
  parameter logic [BIT_LEN-1:0] P              =
    256'd104899928942039473597645237135751317405745389583683433800060134911610808289117
) (
  input logic                clk,
  input logic                reset,
  mont_exit_reducer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BIT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_LEN - BITS_PER_CYCLE);
  localparam logic [BIT_LEN:0]   P_EXT  = {1'b0, P};
  localparam logic [BIT_LEN+1:0] P_EXT2 = {2'b00, P};

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    CORRECT,
    DONE
  } state_t;

  state_t             state;
  logic [BIT_LEN:0]   acc;
  logic [BIT_LEN:0]   acc_next;
  logic [BIT_LEN:0]   acc_sub;
  logic [BIT_LEN+1:0] step_sum;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [BIT_LEN-1:0] o_r;

  // Chained REDC steps: make acc even by adding P when odd, then halve.
  // The sum is formed one bit wider than acc so the carry survives the shift.
  always_comb begin
    acc_next = acc;
    step_sum = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      step_sum = {1'b0, acc_next} + (acc_next[0] ? P_EXT2 : '0);
      acc_next = step_sum[BIT_LEN+1:1];
    end
  end

  // Final acc is at most P, so one conditional subtract lands in [0, P-1].
  assign acc_sub = acc - P_EXT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      o_r         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc        <= {1'b0, bus.X};
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ITERATE;
          end
        end
        ITERATE: begin
          acc <= acc_next;
          cnt <= cnt + CNT_STEP;
          if (cnt == CNT_LAST) begin
            state <= CORRECT;
          end
        end
        CORRECT: begin
          o_r         <= (acc >= P_EXT) ? acc_sub[BIT_LEN-1:0] : acc[BIT_LEN-1:0];
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.O         = o_r;

endmodule

// File: tb/tb_mont_exit_reducer.sv
// Directed bench for mont_exit_reducer. Three BIT_LEN=8, P=251 instances
// (BITS_PER_CYCLE 1/2/4) share one stimulus; R^-1 mod 251 = 201, so
// O = X*201 mod 251. A BIT_LEN=256 instance with default P is checked by
// verifying O < P and O*2^256 mod P == X mod P.
module tb_mont_exit_reducer;

  localparam logic [255:0] PW =
    256'd104899928942039473597645237135751317405745389583683433800060134911610808289117;
  localparam int NW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       in_valid8;
  logic       out_ready8;
  logic [7:0] x8;

  mont_exit_reducer_if #(.BIT_LEN(8))   b1 ();
  mont_exit_reducer_if #(.BIT_LEN(8))   b2 ();
  mont_exit_reducer_if #(.BIT_LEN(8))   b4 ();
  mont_exit_reducer_if #(.BIT_LEN(256)) bw ();

  assign b1.in_valid = in_valid8;
  assign b2.in_valid = in_valid8;
  assign b4.in_valid = in_valid8;
  assign b1.X = x8;
  assign b2.X = x8;
  assign b4.X = x8;
  assign b1.out_ready = out_ready8;
  assign b2.out_ready = out_ready8;
  assign b4.out_ready = out_ready8;

  mont_exit_reducer #(.BIT_LEN(8), .BITS_PER_CYCLE(1), .P(8'd251)) u1 (
    .clk(clk), .reset(rst_n), .bus(b1.slave));
  mont_exit_reducer #(.BIT_LEN(8), .BITS_PER_CYCLE(2), .P(8'd251)) u2 (
    .clk(clk), .reset(rst_n), .bus(b2.slave));
  mont_exit_reducer #(.BIT_LEN(8), .BITS_PER_CYCLE(4), .P(8'd251)) u4 (
    .clk(clk), .reset(rst_n), .bus(b4.slave));
  mont_exit_reducer #(.BIT_LEN(256), .BITS_PER_CYCLE(1), .P(PW)) uw (
    .clk(clk), .reset(rst_n), .bus(bw.slave));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // o * 2^256 mod PW by repeated modular doubling (valid for o < PW).
  function automatic logic [255:0] mul_r_mod_p(input logic [255:0] o);
    logic [256:0] v;
    v = {1'b0, o};
    for (int i = 0; i < 256; i++) begin
      v = v << 1;
      if (v >= {1'b0, PW}) v = v - {1'b0, PW};
    end
    return v[255:0];
  endfunction

  // Called at #1 after a posedge with all 8-bit instances idle and out_ready8=1.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] exp);
    logic       seen [3];
    int         lat  [3];
    logic [7:0] o    [3];
    logic       busy_ok;
    int         want [3];
    want = '{9, 5, 3};
    for (int k = 0; k < 3; k++) begin seen[k] = 1'b0; lat[k] = -1; o[k] = 8'h00; end
    in_valid8 = 1'b1;
    x8 = x;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    x8 = 8'hA5;
    check({tag, "_busy_at_accept"}, 256'(b1.busy), 256'(1));
    busy_ok = 1'b1;
    for (int c = 1; c <= 30 && !(seen[0] && seen[1] && seen[2]); c++) begin
      @(posedge clk); #1;
      if (!seen[0] && !b1.busy) busy_ok = 1'b0;
      if (!seen[0] && b1.out_valid) begin seen[0] = 1'b1; lat[0] = c; o[0] = b1.O; end
      if (!seen[1] && b2.out_valid) begin seen[1] = 1'b1; lat[1] = c; o[1] = b2.O; end
      if (!seen[2] && b4.out_valid) begin seen[2] = 1'b1; lat[2] = c; o[2] = b4.O; end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_lat_bpc%0d", tag, 1 << k), 256'(lat[k]), 256'(want[k]));
      check($sformatf("%s_o_bpc%0d", tag, 1 << k), 256'(o[k]), 256'(exp));
      check($sformatf("%s_o_lt_p_bpc%0d", tag, 1 << k), 256'(o[k] < 8'd251), 256'(1));
    end
    check({tag, "_busy_held"}, 256'(busy_ok), 256'(1));
    @(posedge clk); #1;
    check({tag, "_idle_in_ready"}, 256'(b1.in_ready), 256'(1));
    check({tag, "_idle_busy"}, 256'(b1.busy), 256'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [255:0] xs [NW];
  logic [255:0] exp_q [$];

  initial begin
    in_valid8    = 1'b0;
    out_ready8   = 1'b1;
    x8           = 8'h00;
    bw.in_valid  = 1'b0;
    bw.X         = '0;
    bw.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(b1.in_ready), 256'(1));
    check("rst_out_valid", 256'(b1.out_valid), 256'(0));
    check("rst_busy", 256'(b1.busy), 256'(0));
    check("rst_o", 256'(b1.O), 256'(0));
    check("rst_w_in_ready", 256'(bw.in_ready), 256'(1));
    check("rst_w_o", bw.O, 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8("x5", 8'd5, 8'd1);
    run8("x1", 8'd1, 8'd201);
    run8("x0", 8'd0, 8'd0);
    run8("x250", 8'd250, 8'd50);
    run8("x255", 8'd255, 8'd51);
    run8("x251", 8'd251, 8'd0);

    // Output stall with ignored input pulses.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1;
    x8 = 8'd1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int c = 0; c < 30 && !b1.out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("stall_ov_rise", 256'(b1.out_valid), 256'(1));
    for (int i = 0; i < 20; i++) begin
      in_valid8 = i[0];
      x8 = 8'd77;
      @(posedge clk); #1;
      check($sformatf("stall_ov_%0d", i), 256'(b1.out_valid), 256'(1));
      check($sformatf("stall_o_%0d", i), 256'(b1.O), 256'(201));
      check($sformatf("stall_in_ready_%0d", i), 256'(b1.in_ready), 256'(0));
    end
    check("stall_o_bpc4", 256'(b4.O), 256'(201));
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("release_ov", 256'(b1.out_valid), 256'(0));
    check("release_in_ready", 256'(b1.in_ready), 256'(1));
    check("release_busy", 256'(b1.busy), 256'(0));
    check("release_o_kept", 256'(b1.O), 256'(201));
    check("release_in_ready_bpc2", 256'(b2.in_ready), 256'(1));

    // Asynchronous reset during ITERATE.
    in_valid8 = 1'b1;
    x8 = 8'd5;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_abort_busy", 256'(b1.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 256'(b1.in_ready), 256'(1));
    check("abort_out_valid", 256'(b1.out_valid), 256'(0));
    check("abort_busy", 256'(b1.busy), 256'(0));
    check("abort_o", 256'(b1.O), 256'(0));
    check("abort_busy_bpc2", 256'(b2.busy), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8("post_rst_x1", 8'd1, 8'd201);

    // Full-width instance: corner values plus random, with output stalls.
    xs[0] = '0;
    xs[1] = PW - 256'd1;
    xs[2] = PW;
    xs[3] = '1;
    for (int i = 4; i < NW; i++) begin
      xs[i] = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    end
    fork
      begin : source
        logic was;
        logic accepted;
        for (int i = 0; i < NW; i++) begin
          bw.in_valid = 1'b1;
          bw.X = xs[i];
          accepted = 1'b0;
          for (int c = 0; c < 3000 && !accepted; c++) begin
            was = bw.in_ready;
            @(posedge clk); #1;
            accepted = was;
          end
          if (!accepted) check($sformatf("w_accept_%0d", i), 256'(0), 256'(1));
          exp_q.push_back(xs[i]);
          bw.in_valid = 1'b0;
          bw.X = ~xs[i];
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin : sink
        int got;
        logic hs;
        logic [255:0] ov;
        logic [255:0] xv;
        logic [255:0] xm;
        got = 0;
        for (int c = 0; c < 20000 && got < NW; c++) begin
          bw.out_ready = 1'($urandom_range(0, 1));
          hs = bw.out_valid && bw.out_ready;
          ov = bw.O;
          @(posedge clk); #1;
          if (hs) begin
            if (exp_q.size() == 0) begin
              check("w_unexpected_output", 256'(1), 256'(0));
            end else begin
              xv = exp_q.pop_front();
              xm = (xv >= PW) ? xv - PW : xv;
              check($sformatf("w_o_lt_p_%0d", got), 256'(ov < PW), 256'(1));
              check($sformatf("w_oR_modp_%0d", got), mul_r_mod_p(ov), xm);
              if (xv == '0 || xv == PW) check($sformatf("w_zero_%0d", got), ov, 256'(0));
            end
            got++;
          end
        end
        check("w_result_count", 256'(got), 256'(NW));
        bw.out_ready = 1'b0;
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mont_exit_reducer.md
Name: mont_exit_reducer

Overview:
- Converts a value out of the Montgomery domain: O = X · R⁻¹ mod P, with R = 2^BIT_LEN.
- This is the inverse of the into-Montgomery transform used on the modular-reduction path. It sits at the output of the field arithmetic datapath, before results leave the core.
- Implemented as an iterative, multiplier-free, radix-2^BITS_PER_CYCLE REDC with valid/ready handshakes on both sides.

Parameters:
- BIT_LEN, 256, operand/result width and Montgomery exponent (R = 2^BIT_LEN).
- BITS_PER_CYCLE, 1, REDC bit-steps per clock; legal values 1, 2, 4; must divide BIT_LEN.
- P, 256'd104899928942039473597645237135751317405745389583683433800060134911610808289117, modulus; must be odd and < 2^BIT_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  X is valid.
- in_ready  output  1  block can accept X.
- X  input  BIT_LEN  Montgomery-form operand; any value in 0..2^BIT_LEN-1 is legal.
- out_valid  output  1  O is valid.
- out_ready  input  1  downstream accepts O.
- O  output  BIT_LEN  result X·R⁻¹ mod P, always in [0, P-1].
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; in_ready=1, out_valid=0, busy=0, O=0; accumulator and counter cleared.
- Reset asserted mid-operation aborts the operation with no output; the first post-reset accept starts clean.
- Datapath: accumulator acc is BIT_LEN+1 bits wide.
- One REDC step: if acc[0]=1 then acc = acc + P; then acc = acc >> 1. The add is performed at BIT_LEN+2 bits before the shift, so no carry is lost.
- Each clock in ITERATE performs BITS_PER_CYCLE chained steps combinationally.
- Invariant: acc ≤ max(X, P) throughout; the final acc ≤ P.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: acc←{0,X}, step counter←0, go to ITERATE.
- State ITERATE:
  - in_ready=0. Apply BITS_PER_CYCLE steps and counter += BITS_PER_CYCLE.
  - When the counter reaches BIT_LEN after this edge, go to CORRECT.
  - Takes exactly BIT_LEN/BITS_PER_CYCLE cycles.
- State CORRECT:
  - O ← (acc ≥ P) ? acc−P : acc[BIT_LEN-1:0].
  - out_valid←1, go to DONE.
- State DONE:
  - out_valid=1; O and out_valid hold stable until out_ready=1.
  - On out_valid&out_ready: out_valid←0, go to IDLE.
  - O retains its last value after the handshake.
- Latency: out_valid rises BIT_LEN/BITS_PER_CYCLE + 1 clock edges after the accept edge (257 for defaults).
- Throughput: one result per BIT_LEN/BITS_PER_CYCLE + 3 cycles at best; no overlap between operations.
- in_ready is deasserted in every state except IDLE; in_valid outside IDLE is ignored (the source must hold X).
- out_ready asserted outside DONE has no effect.
- Output handshake and new input acceptance never occur in the same cycle (IDLE is always one full cycle).
- X=0 gives O=0. X ≥ P is legal and reduced correctly. X=P gives O=0.
- busy is registered from the state: high in ITERATE, CORRECT and DONE.

Test Plan:
(All directed vectors use BIT_LEN=8, P=251, so R⁻¹ mod P = 201.)
- Reset, then X=5, BITS_PER_CYCLE=1, out_ready held 1 -> O=1; out_valid rises exactly 9 edges after accept; busy high from accept to handshake.
- Inputs X=1, 0, 250, 255, 251 -> outputs O=201, 0, 50, 51, 0 respectively; all outputs < 251.
- BITS_PER_CYCLE=2 and 4, X=250 -> O=50 with latency 5 and 3 edges respectively.
- Hold out_ready=0 for 20 cycles after out_valid with X=1 -> O=201 and out_valid stable; in_ready=0 throughout; in_valid pulses with other X are ignored. Release out_ready -> IDLE, in_ready=1 next cycle.
- Drive reset low while in ITERATE with X=5 -> all outputs reset immediately (asynchronously). Then X=1 -> O=201 with no residue from the aborted operation.
- Defaults (BIT_LEN=256): random X, including 0, P−1, P and 2^256−1 -> O equals the reference model (X·2^-256 mod P); back-to-back operations with random out_ready stalls.
